silife_max7219_driver: RTL and testbench
========================================

Name: silife_max7219_driver

Overview:
Downstream display stage for the 8x8 life grid.
- Reads the grid one row at a time through the grid's secondary read port (row select out, row cells in).
- Serialises each row into a 16-bit MAX7219 word and drives the chip over a 3-wire SPI link.
- After reset it runs the MAX7219 init sequence once, then sends one 8-word frame per refresh request.

Parameters:
CLK_DIV, 4, clk cycles per SPI clock half-period; legal range 1..255
INTENSITY, 4'h8, value written to MAX7219 intensity register 0x0A

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
start  input  1  one-cycle refresh request; sampled only in IDLE
row_select  output  3  row index presented to the grid read port
cells  input  8  grid row data for row_select; combinational, valid the same cycle
busy  output  1  high whenever state is not IDLE
frame_done  output  1  one-cycle pulse after the last gap of a display frame
spi_cs_n  output  1  MAX7219 LOAD/CS, active-low
spi_sck  output  1  SPI clock, idle low
spi_mosi  output  1  SPI data, MSB first

Behaviour:
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, row_select=0, frame_done=0, busy=1, state=INIT.
- Reset asserted mid-word: outputs return to reset values immediately (asynchronously). The init sequence restarts from word 0 after reset is released.
- Word format: {4'h0, addr[3:0], data[7:0]}, sent MSB first.
- Init words, in order:
  - 0x0C01 (normal operation)
  - 0x0900 (no decode)
  - {8'h0A, 4'h0, INTENSITY}
  - 0x0B07 (scan all 8 digits)
  - 0x0F00 (display test off)
- Frame words: for r = 0..7, addr = r+1, data = cells with row_select = r.
- Cell data is captured into the shift register in the LOAD cycle only. The grid may step mid-frame; tearing between rows is acceptable.
- Timing of one word:
  - LOAD: 1 cycle. spi_cs_n falls, spi_mosi = bit15, spi_sck = 0.
  - SHIFT: 16 bit periods. In each period spi_sck is low for CLK_DIV cycles, then high for CLK_DIV cycles. spi_mosi changes only on the cycle sck falls (and in LOAD for bit15).
  - GAP: spi_cs_n high and spi_sck low for 2*CLK_DIV cycles. The rising edge of cs latches the word in the chip.
  - Total: 1 + 34*CLK_DIV cycles per word. With CLK_DIV=4 this is 137 cycles per word and 1096 cycles per frame.
- FSM states: INIT_LOAD/INIT_SHIFT/INIT_GAP (5 words), IDLE, FRM_LOAD/FRM_SHIFT/FRM_GAP (8 words).
- Transitions:
  - After the 5th init GAP -> IDLE. No frame_done is generated for init.
  - IDLE with start=1 -> FRM_LOAD, row 0.
  - After the row-7 GAP -> IDLE, with frame_done high for that one cycle.
- start while busy is ignored, not queued. start in the first IDLE cycle after frame_done is accepted.
- Counters:
  - word index: 3 bits.
  - bit count: 4 bits, counts 15 down to 0; wraps only through LOAD.
  - divider: 8 bits, counts CLK_DIV-1 down to 0.
- row_select holds the current row index during FRM states and holds 0 otherwise.

Optional Feature:
MAX7219_AUTO_REFRESH_EN
- Defined: IDLE lasts exactly one cycle and the next frame starts automatically. The start input is ignored. frame_done still pulses once per frame.
- Undefined: frames are sent only on start, as described above.

Decomposition:
- Package silife_max7219_pkg holds:
  - register address constants: REG_DIGIT0=4'h1, REG_DECODE=4'h9, REG_INTENSITY=4'hA, REG_SCANLIM=4'hB, REG_SHUTDOWN=4'hC, REG_TEST=4'hF
  - the FSM state enum
  - the 5-entry init-word constant table
- One sub-module, silife_spi_tx16, is natural. Interface: load strobe plus 16-bit word in; done pulse; cs/sck/mosi out; CLK_DIV passed through. It owns the divider, bit counter and GAP timing. The top level owns init/frame sequencing and row addressing.

Test Plan:
- Release reset, CLK_DIV=1, INTENSITY=4'h8 -> SPI monitor decodes exactly 0x0C01, 0x0900, 0x0A08, 0x0B07, 0x0F00. busy falls 175 cycles after reset release.
- Grid rows hold 0x01,0x02,...,0x80 (row r = 1<<r); pulse start -> words 0x0101, 0x0202, 0x0304 ... 0x0880 are decoded. frame_done pulses once, 8*(1+34*CLK_DIV) cycles after start.
- CLK_DIV=4 -> every sck high and low phase is 4 cycles, cs gap is 8 cycles, mosi is stable across every sck rising edge.
- Pulse start during init and again mid-frame -> neither pulse is queued. Exactly one frame is sent, and only for a start issued in IDLE.
- Assert reset during bit 7 of the row-3 word -> cs_n=1, sck=0, mosi=0 in the same cycle. After release the full init sequence repeats before IDLE.
- With MAX7219_AUTO_REFRESH_EN defined and start held 0 -> back-to-back frames, with frame_done pulses spaced 8*(1+34*CLK_DIV)+1 cycles apart.

Source files
------------

// File: rtl/silife_max7219_pkg.sv
// silife_max7219_pkg
// Shared definitions for the MAX7219 display driver:
//   - MAX7219 register addresses
//   - driver FSM state and SPI transmitter phase encodings
//   - the power-up init word table and a lookup helper
package silife_max7219_pkg;

    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIM   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    localparam int N_INIT_WORDS = 5;
    localparam int N_ROWS       = 8;

    // The intensity entry carries a zero data nibble; the driver's
    // INTENSITY parameter is merged in by init_word().
    localparam logic [15:0] INIT_WORDS [N_INIT_WORDS] = '{
        {4'h0, REG_SHUTDOWN,  8'h01},
        {4'h0, REG_DECODE,    8'h00},
        {4'h0, REG_INTENSITY, 8'h00},
        {4'h0, REG_SCANLIM,   8'h07},
        {4'h0, REG_TEST,      8'h00}
    };

    typedef enum logic [2:0] {
        ST_INIT_LOAD,
        ST_INIT_SHIFT,
        ST_INIT_GAP,
        ST_IDLE,
        ST_FRM_LOAD,
        ST_FRM_SHIFT,
        ST_FRM_GAP
    } drv_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_GAP
    } tx_phase_e;

    function automatic logic [15:0] init_word(input logic [2:0] idx,
                                              input logic [3:0] intensity);
        logic [15:0] w;
        w = 16'h0000;
        if (idx < 3'(N_INIT_WORDS)) begin
            w = INIT_WORDS[idx];
        end
        if (idx == 3'd2) begin
            w[3:0] = intensity;
        end
        return w;
    endfunction

endpackage

// File: rtl/silife_max7219_driver_spi_tx16.sv
// silife_spi_tx16
// Serialises one 16-bit word onto a 3-wire MAX7219 link, MSB first.
// The cycle in which 'load' is high is the LOAD cycle on the wire
// (cs_n low, mosi = bit15); the word is captured at the end of it.
// It is followed by 16 bit periods (sck low CLK_DIV, high CLK_DIV) and
// a 2*CLK_DIV gap with cs_n high.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   load, word      one-cycle start strobe and the word to send
//   in_gap          transmitter is in the cs-high gap
//   done            last cycle of the gap
//   spi_cs_n/sck/mosi  serial link
module silife_spi_tx16
    import silife_max7219_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] word,
    output logic        in_gap,
    output logic        done,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    tx_phase_e   phase_q, phase_d;
    logic [15:0] shreg_q, shreg_d;
    logic [3:0]  bit_q,   bit_d;
    logic [7:0]  div_q,   div_d;
    logic        high_q,  high_d;
    logic        load_act;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= TX_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            high_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            high_q  <= high_d;
        end
    end

    // high_q selects the second half of a bit period (sck high) or the
    // second half of the gap, so the 8-bit divider never needs 2*CLK_DIV.
    always_comb begin
        phase_d = phase_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        high_d  = high_q;
        if (load) begin
            phase_d = TX_SHIFT;
            shreg_d = word;
            bit_d   = 4'd15;
            div_d   = DIV_LAST;
            high_d  = 1'b0;
        end else if (phase_q != TX_IDLE) begin
            if (div_q != 8'd0) begin
                div_d = div_q - 8'd1;
            end else if (!high_q) begin
                high_d = 1'b1;
                div_d  = DIV_LAST;
            end else if (phase_q == TX_GAP) begin
                phase_d = TX_IDLE;
                high_d  = 1'b0;
            end else if (bit_q == 4'd0) begin
                phase_d = TX_GAP;
                high_d  = 1'b0;
                div_d   = DIV_LAST;
            end else begin
                bit_d   = bit_q - 4'd1;
                shreg_d = shreg_q << 1;
                high_d  = 1'b0;
                div_d   = DIV_LAST;
            end
        end
    end

    // Reset masks the LOAD strobe so the pins reach their idle values
    // immediately while reset is held.
    assign load_act = load & ~reset;

    assign in_gap   = (phase_q == TX_GAP);
    assign done     = in_gap && high_q && (div_q == 8'd0);
    assign spi_cs_n = ~(load_act | (phase_q == TX_SHIFT));
    assign spi_sck  = (phase_q == TX_SHIFT) && high_q;
    assign spi_mosi = load_act ? word[15] : ((phase_q == TX_SHIFT) && shreg_q[15]);

endmodule

// File: rtl/silife_max7219_driver.sv
// silife_max7219_driver
// Display stage for the 8x8 life grid. After reset it sends the five
// MAX7219 init words, then one 8-word frame (row r -> digit register
// r+1) per refresh request, reading rows through the grid's secondary
// read port.
// Optional feature macro: MAX7219_AUTO_REFRESH_EN -- when defined, IDLE
// lasts one cycle and frames repeat back-to-back; start is ignored.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           refresh request, honoured only in IDLE
//   row_select      row index to the grid read port (0 outside frames)
//   cells           row data for row_select (combinational)
//   busy            high whenever not IDLE
//   frame_done      one-cycle pulse in the IDLE cycle after a frame
//   spi_cs_n/sck/mosi  MAX7219 link
module silife_max7219_driver
    import silife_max7219_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [2:0] row_select,
    input  logic [7:0] cells,
    output logic       busy,
    output logic       frame_done,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi
);

    drv_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        frame_done_q, frame_done_d;
    logic        load, tx_gap, tx_done, in_frame, go;
    logic [15:0] word;

`ifdef MAX7219_AUTO_REFRESH_EN
    logic unused_start;
    assign unused_start = start;
    assign go = 1'b1;
`else
    assign go = start;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT_LOAD;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    // The transmitter times each word; this FSM only follows it and picks
    // the next word. SHIFT->GAP may trail the wire by a cycle, which is
    // harmless because the gap is at least two cycles long.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_INIT_LOAD:  state_d = ST_INIT_SHIFT;
            ST_INIT_SHIFT: if (tx_gap) state_d = ST_INIT_GAP;
            ST_INIT_GAP: begin
                if (tx_done) begin
                    if (idx_q == 3'(N_INIT_WORDS - 1)) begin
                        state_d = ST_IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_INIT_LOAD;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_FRM_LOAD;
                    idx_d   = 3'd0;
                end
            end
            ST_FRM_LOAD:  state_d = ST_FRM_SHIFT;
            ST_FRM_SHIFT: if (tx_gap) state_d = ST_FRM_GAP;
            ST_FRM_GAP: begin
                if (tx_done) begin
                    if (idx_q == 3'(N_ROWS - 1)) begin
                        state_d      = ST_IDLE;
                        idx_d        = 3'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_FRM_LOAD;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_INIT_LOAD;
        endcase
    end

    assign load     = (state_q == ST_INIT_LOAD) || (state_q == ST_FRM_LOAD);
    assign in_frame = (state_q == ST_FRM_LOAD) || (state_q == ST_FRM_SHIFT) ||
                      (state_q == ST_FRM_GAP);

    // Row data only matters in FRM_LOAD, where the transmitter captures it.
    assign word = (state_q == ST_FRM_LOAD) ? {4'h0, {1'b0, idx_q} + 4'd1, cells}
                                           : init_word(idx_q, INTENSITY);

    assign row_select = in_frame ? idx_q : 3'd0;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;

    silife_spi_tx16 #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .word     (word),
        .in_gap   (tx_gap),
        .done     (tx_done),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi)
    );

endmodule

// File: tb/tb_silife_max7219_driver.sv
// Testbench for silife_max7219_driver (CLK_DIV=4, INTENSITY=4'h8).
// A cycle-level expectation queue is built from the word list of each
// init sequence / frame and compared against the pins on every negedge.
// A separate SPI decoder recovers words for literal checks.
module tb_silife_max7219_driver;

    localparam int CDIV     = 4;
    localparam int WORD_CYC = 1 + 34 * CDIV;
`ifdef MAX7219_AUTO_REFRESH_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam logic [15:0] INIT_EXP [5] = '{16'h0C01, 16'h0900, 16'h0A08,
                                             16'h0B07, 16'h0F00};
    localparam logic [15:0] RAMP_EXP [8] = '{16'h0101, 16'h0202, 16'h0304, 16'h0408,
                                             16'h0510, 16'h0620, 16'h0740, 16'h0880};

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] row_select;
    logic [7:0] cells;
    logic       busy, frame_done, spi_cs_n, spi_sck, spi_mosi;
    logic [7:0] grid [8];

    int n_cmp = 0;
    int n_bad = 0;

    assign cells = grid[row_select];

    silife_max7219_driver #(
        .CLK_DIV   (CDIV),
        .INTENSITY (4'h8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .row_select (row_select),
        .cells      (cells),
        .busy       (busy),
        .frame_done (frame_done),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       cs_n;
        logic       sck;
        logic       mosi;
        logic       bsy;
        logic       fd;
        logic [2:0] row;
        logic       idle;
    } exp_t;

    exp_t exq[$];

    function automatic exp_t mk(input logic cs_n, input logic sck, input logic mosi,
                                input logic bsy, input logic fd, input logic [2:0] row,
                                input logic idle);
        exp_t e;
        e.cs_n = cs_n; e.sck = sck; e.mosi = mosi; e.bsy = bsy;
        e.fd = fd; e.row = row; e.idle = idle;
        return e;
    endfunction

    task automatic push_word(input logic [15:0] w, input logic [2:0] row);
        exq.push_back(mk(1'b0, 1'b0, w[15], 1'b1, 1'b0, row, 1'b0));
        for (int b = 15; b >= 0; b--) begin
            for (int k = 0; k < CDIV; k++) exq.push_back(mk(1'b0, 1'b0, w[b], 1'b1, 1'b0, row, 1'b0));
            for (int k = 0; k < CDIV; k++) exq.push_back(mk(1'b0, 1'b1, w[b], 1'b1, 1'b0, row, 1'b0));
        end
        for (int k = 0; k < 2 * CDIV; k++) exq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, row, 1'b0));
    endtask

    task automatic push_init();
        for (int i = 0; i < 5; i++) push_word(INIT_EXP[i], 3'd0);
    endtask

    task automatic push_frame();
        for (int r = 0; r < 8; r++) push_word({4'h0, 4'(r + 1), grid[r]}, 3'(r));
        exq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1));
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [7:0] act, want;
        act = {spi_cs_n, spi_sck, spi_mosi, busy, frame_done, row_select};
        if (reset) begin
            check("pins_in_reset", 32'(act), 32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0}));
        end else begin
            if (exq.size() > 0) e = exq.pop_front();
            else                e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
            want = {e.cs_n, e.sck, e.mosi, e.bsy, e.fd, e.row};
            check("cs_sck_mosi_busy_fd_row", 32'(act), 32'(want));
            if (e.idle && (AUTO || start === 1'b1)) push_frame();
        end
    end

    // ---------------- SPI word decoder ----------------
    logic [15:0] dec_sh = 16'h0;
    int          dec_n  = 0;
    logic [15:0] dec_q[$];

    always @(negedge spi_cs_n) dec_n = 0;
    always @(posedge spi_sck) begin
        dec_sh = {dec_sh[14:0], spi_mosi};
        dec_n++;
    end
    always @(posedge spi_cs_n) if (dec_n == 16) dec_q.push_back(dec_sh);

    task automatic check_decoded(input string name, input logic [15:0] want [], input int cnt);
        check({name, "_count"}, 32'(dec_q.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < dec_q.size(); i++) check(name, 32'(dec_q[i]), 32'(want[i]));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b0;
        push_init();
    endtask

    // Waits for busy to drop; start is pulsed once at cycle 'ign' (ignored by DUT).
    task automatic wait_idle(input int ign, output int n);
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            start = (n == ign);
            tick();
            n++;
        end
        start = 1'b0;
    endtask

    // Issues start in IDLE, then pulses start again at frame cycle 'mid'.
    // n = cycles from the edge that samples start to frame_done.
    task automatic run_frame(input int mid, output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (frame_done !== 1'b1 && n < 3000) begin
            start = (n == mid);
            tick();
            n++;
        end
        start = 1'b0;
    endtask

    task automatic random_grid();
        for (int r = 0; r < 8; r++) grid[r] = 8'($urandom_range(0, 255));
    endtask

    logic [15:0] wl [];

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        for (int r = 0; r < 8; r++) grid[r] = 8'(1 << r);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        dec_q.delete();
        release_reset();
`ifdef MAX7219_AUTO_REFRESH_EN
        n = 0;
        while (frame_done !== 1'b1 && n < 5000) begin tick(); n++; end
        check("first_fd_latency", 32'(n), 32'(5 * WORD_CYC + 1 + 8 * WORD_CYC));
        for (int k = 0; k < 2; k++) begin
            tick();
            n = 1;
            while (frame_done !== 1'b1 && n < 3000) begin tick(); n++; end
            check("fd_spacing", 32'(n), 32'd1097);
        end
`else
        wait_idle(40, n);
        check("busy_fall_after_release", 32'(n), 32'd685);
        wl = new[5];
        for (int i = 0; i < 5; i++) wl[i] = INIT_EXP[i];
        check_decoded("init_word", wl, 5);

        // ramp pattern frame, with an ignored start mid-frame
        repeat (3) tick();
        dec_q.delete();
        run_frame(300, n);
        check("frame_latency", 32'(n), 32'd1096);
        wl = new[8];
        for (int i = 0; i < 8; i++) wl[i] = RAMP_EXP[i];
        check_decoded("ramp_word", wl, 8);
        tick();
        check("fd_one_cycle", 32'(frame_done), 32'd0);

        // randomized frames; gap 0 starts in the frame_done cycle
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, 3)) tick();
            random_grid();
            run_frame($urandom_range(2, 1090), n);
            check("rand_frame_latency", 32'(n), 32'd1096);
        end

        // reset during bit 7 of the row-3 word
        tick();
        random_grid();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3 * WORD_CYC + 1 + 8 * 2 * CDIV + 2) tick();
        check("cs_low_before_reset", 32'(spi_cs_n), 32'd0);
        check("row3_before_reset", 32'(row_select), 32'd3);
        #1;
        reset = 1'b1;
        exq.delete();
        #1;
        check("mid_rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("mid_rst_sck", 32'(spi_sck), 32'd0);
        check("mid_rst_mosi", 32'(spi_mosi), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_row", 32'(row_select), 32'd0);
        dec_q.delete();
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        wait_idle(-1, n);
        check("busy_fall_after_rerelease", 32'(n), 32'd685);
        wl = new[5];
        for (int i = 0; i < 5; i++) wl[i] = INIT_EXP[i];
        check_decoded("reinit_word", wl, 5);
        repeat (5) tick();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
